execute_stage: RTL
==================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 flush  in  1  synchronous squash of the held/in-flight instruction.
REQ-004 in_valid  in  1  decode presents an instruction this cycle.
REQ-005 pc  in  32  instruction address.
REQ-006 rs1_data  in  32  operand A.
REQ-007 rs2_data  in  32  operand B / store data.
REQ-008 imm  in  32  sign-extended immediate.
REQ-009 alu_op  in  5  operation code (package encoding).
REQ-010 AluSrc  in  1  1 selects imm as operand B.
REQ-011 br_funct3  in  3  branch condition: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
REQ-012 Branch  in  1  conditional branch instruction.
REQ-013 Jump  in  1  unconditional jump; result is pc+4.
REQ-014 in_ctrl  in  6  {MemRead, MemWrite, MemToReg, RegWrite, RegDataSrc, PCSrc}, passed through.
REQ-015 in_RegDest  in  5  destination register, passed through.
REQ-016 stall  out  1  combinational; upstream holds all inputs while high.
REQ-017 out_valid  out  1  registered result valid toward the memory stage.
REQ-018 alu_result  out  32  result/effective address (memory stage addr).
REQ-019 store_data  out  32  registered rs2_data (memory stage data_in).
REQ-020 out_ctrl  out  6  registered in_ctrl, same bit order.
REQ-021 out_RegDest  out  5  registered in_RegDest.
REQ-022 branch_taken  out  1  registered redirect request (Jump, or Branch with condition true).
REQ-023 branch_target  out  32  registered pc+imm.

Function
REQ-024 Single-cycle ops (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, PASSB) SHALL appear on outputs one edge after capture; shift amount = operand B[4:0]; all arithmetic mod 2^32.
REQ-025 An edge with in_valid=0 or stall=1 in IDLE SHALL register a bubble: out_valid=0, out_ctrl=0, branch_taken=0.
REQ-026 FSM states IDLE, BUSY; IDLE->BUSY on in_valid with MUL, MULH, MULHU, DIV, DIVU, REM or REMU (except REQ-029 cases); BUSY->IDLE after 32 iterations or flush.
REQ-027 stall SHALL be 1 when (IDLE and in_valid and multi-cycle op) or (BUSY and iteration count != 31); 0 otherwise.
REQ-028 Multi-cycle result SHALL register with out_valid=1 on the 32nd BUSY edge (33 edges after capture); bubbles are registered during BUSY.
REQ-029 Divide by zero: quotient 0xFFFFFFFF, remainder = dividend; signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0; both single-cycle, no BUSY.
REQ-030 Signed mul/div SHALL operate on magnitudes with result sign fix-up; remainder takes the dividend's sign.
REQ-031 Jump SHALL produce alu_result=pc+4 and branch_taken=1; Branch SHALL produce alu_result=0 and branch_taken per br_funct3.
REQ-032 flush SHALL take priority over capture and completion: next edge registers a bubble and forces IDLE.

Reset
REQ-033 rst SHALL asynchronously force IDLE, iteration count 0, and every registered output to 0, including mid-BUSY; stall SHALL then be driven per REQ-027.

Structure
REQ-034 Package exec_pkg SHALL hold alu_op encodings, br_funct3 encodings, in_ctrl bit indices and the FSM state type.
REQ-035 Iterative multiply/divide datapath SHALL be a sub-module muldiv_unit (start, op, a, b -> busy, done, result).

Verification
REQ-036 ADD rs1=5, rs2=0xFFFFFFFF -> alu_result=4, out_valid=1 next edge, stall never high.
REQ-037 MUL 7*6 -> stall high 32 cycles, alu_result=42 on edge 33; MULH -1*-1 -> 0.
REQ-038 DIV 7/0 -> 0xFFFFFFFF; REM 0x80000000 % -1 -> 0; both single-cycle.
REQ-039 BLT rs1=-1, rs2=1, pc=0x100, imm=0x20 -> branch_taken=1, branch_target=0x120.
REQ-040 DIVU started, flush at BUSY cycle 10 -> bubble next edge, IDLE; repeat with rst -> all outputs 0 immediately.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU operations, branch conditions,
// control-bundle bit positions and the sequencing state type.
package exec_pkg;

   localparam int DATA_W = 32;
   localparam int ITERS  = 32;

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,
      OP_SUB   = 5'd1,
      OP_AND   = 5'd2,
      OP_OR    = 5'd3,
      OP_XOR   = 5'd4,
      OP_SLL   = 5'd5,
      OP_SRL   = 5'd6,
      OP_SRA   = 5'd7,
      OP_SLT   = 5'd8,
      OP_SLTU  = 5'd9,
      OP_PASSB = 5'd10,
      OP_MUL   = 5'd11,
      OP_MULH  = 5'd12,
      OP_MULHU = 5'd13,
      OP_DIV   = 5'd14,
      OP_DIVU  = 5'd15,
      OP_REM   = 5'd16,
      OP_REMU  = 5'd17
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } br_funct3_e;

   // Bit positions inside the 6-bit control bundle
   localparam int CTRL_MEM_READ    = 5;
   localparam int CTRL_MEM_WRITE   = 4;
   localparam int CTRL_MEM_TO_REG  = 3;
   localparam int CTRL_REG_WRITE   = 2;
   localparam int CTRL_REG_DATASRC = 1;
   localparam int CTRL_PCSRC       = 0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } exec_state_e;

   function automatic logic is_multi_op(alu_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_div_op(alu_op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

endpackage

// File: rtl/execute_stage_muldiv_unit.sv
// Iterative 32-step multiplier / restoring divider working on operand
// magnitudes; the sign of the result is restored on the final step.
module muldiv_unit
   import exec_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  alu_op_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   logic [2*DATA_W-1:0] acc_p0;
   logic [2*DATA_W-1:0] acc_step;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   opd_p0;
   logic [DATA_W-1:0]   a_mag;
   logic [DATA_W-1:0]   b_mag;
   logic [DATA_W-1:0]   quo;
   logic [DATA_W-1:0]   rem;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic                div_ge;
   logic                a_neg;
   logic                b_neg;
   logic                op_signed;
   logic [4:0]          cnt_p0;
   logic                busy_p0;
   logic                neg_res_p0;
   logic                neg_rem_p0;
   alu_op_e             op_p0;

   function automatic logic [DATA_W-1:0] cond_neg(logic [DATA_W-1:0] v, logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*DATA_W-1:0] cond_neg_wide(logic [2*DATA_W-1:0] v, logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   // Operand sign detection and magnitude extraction at start
   always_comb begin
      op_signed = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      a_neg     = op_signed & a[DATA_W-1];
      b_neg     = op_signed & b[DATA_W-1];
      a_mag     = cond_neg(a, a_neg);
      b_mag     = cond_neg(b, b_neg);
   end

   // One shift-add or restore-subtract step, plus sign fix-up of the final value
   always_comb begin
      mul_sum   = {1'b0, acc_p0[2*DATA_W-1:DATA_W]} + (acc_p0[0] ? {1'b0, opd_p0} : '0);
      div_shift = {acc_p0[2*DATA_W-1:DATA_W], acc_p0[DATA_W-1]};
      div_ge    = (div_shift >= {1'b0, opd_p0});
      if (is_div_op(op_p0)) begin
         // partial remainder is always below twice the divisor, so the
         // 32-bit wrapped difference is exact whenever div_ge holds
         acc_step = {(div_ge ? (div_shift[DATA_W-1:0] - opd_p0) : div_shift[DATA_W-1:0]),
                     acc_p0[DATA_W-2:0], div_ge};
      end else begin
         acc_step = {mul_sum, acc_p0[DATA_W-1:1]};
      end
      prod = cond_neg_wide(acc_step, neg_res_p0);
      quo  = cond_neg(acc_step[DATA_W-1:0], neg_res_p0);
      rem  = cond_neg(acc_step[2*DATA_W-1:DATA_W], neg_rem_p0);
      case (op_p0)
         OP_MUL:           result = prod[DATA_W-1:0];
         OP_MULH,
         OP_MULHU:         result = prod[2*DATA_W-1:DATA_W];
         OP_DIV, OP_DIVU:  result = quo;
         default:          result = rem;
      endcase
   end

   // Iteration control: count 32 steps, abortable by a flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_p0 <= 1'b0;
         cnt_p0  <= '0;
      end else if (abort) begin
         busy_p0 <= 1'b0;
         cnt_p0  <= '0;
      end else if (start) begin
         busy_p0 <= 1'b1;
         cnt_p0  <= '0;
      end else if (busy_p0) begin
         cnt_p0 <= cnt_p0 + 5'd1;
         if (cnt_p0 == 5'(ITERS - 1)) busy_p0 <= 1'b0;
      end
   end

   // Datapath registers: load magnitudes on start, then step each busy cycle
   always_ff @(posedge clk) begin
      if (start) begin
         op_p0      <= op;
         opd_p0     <= is_div_op(op) ? b_mag : a_mag;
         acc_p0     <= {{DATA_W{1'b0}}, (is_div_op(op) ? a_mag : b_mag)};
         neg_res_p0 <= a_neg ^ b_neg;
         neg_rem_p0 <= a_neg;
      end else if (busy_p0) begin
         acc_p0 <= acc_step;
      end
   end

   assign busy = busy_p0;
   assign done = busy_p0 && (cnt_p0 == 5'(ITERS - 1));

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, branch/jump resolution and an iterative
// multiply/divide path that stalls decode until its result registers.
module execute_stage
   import exec_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] imm,
   input  logic [4:0]  alu_op,
   input  logic        AluSrc,
   input  logic [2:0]  br_funct3,
   input  logic        Branch,
   input  logic        Jump,
   input  logic [5:0]  in_ctrl,
   input  logic [4:0]  in_RegDest,
   output logic        stall,
   output logic        out_valid,
   output logic [31:0] alu_result,
   output logic [31:0] store_data,
   output logic [5:0]  out_ctrl,
   output logic [4:0]  out_RegDest,
   output logic        branch_taken,
   output logic [31:0] branch_target
);

   alu_op_e            op;
   exec_state_e        state;
   exec_state_e        state_d;
   logic [DATA_W-1:0]  opb;
   logic signed [31:0] sa;
   logic signed [31:0] sb;
   logic signed [31:0] s2;
   logic [DATA_W-1:0]  single_res;
   logic               br_cond;
   logic               div_zero;
   logic               div_ovf;
   logic               multi;
   logic               start;
   logic               md_busy;
   logic               md_done;
   logic [DATA_W-1:0]  md_result;

   assign op  = alu_op_e'(alu_op);
   assign opb = AluSrc ? imm : rs2_data;
   assign sa  = rs1_data;
   assign sb  = opb;
   assign s2  = rs2_data;

   // Division corner cases resolve in one cycle and never enter the iterative path
   always_comb begin
      div_zero = is_div_op(op) && (opb == '0);
      div_ovf  = (op inside {OP_DIV, OP_REM}) && (rs1_data == 32'h8000_0000) && (opb == 32'hFFFF_FFFF);
      multi    = is_multi_op(op) && !Branch && !Jump && !div_zero && !div_ovf;
   end

   // Single-cycle result: jump link address, zero for branches, else ALU
   always_comb begin
      single_res = '0;
      if (Jump) begin
         single_res = pc + 32'd4;
      end else if (!Branch) begin
         case (op)
            OP_ADD:          single_res = rs1_data + opb;
            OP_SUB:          single_res = rs1_data - opb;
            OP_AND:          single_res = rs1_data & opb;
            OP_OR:           single_res = rs1_data | opb;
            OP_XOR:          single_res = rs1_data ^ opb;
            OP_SLL:          single_res = rs1_data << opb[4:0];
            OP_SRL:          single_res = rs1_data >> opb[4:0];
            OP_SRA:          single_res = sa >>> opb[4:0];
            OP_SLT:          single_res = {31'b0, (sa < sb)};
            OP_SLTU:         single_res = {31'b0, (rs1_data < opb)};
            OP_PASSB:        single_res = opb;
            OP_DIV, OP_DIVU: single_res = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
            OP_REM, OP_REMU: single_res = div_zero ? rs1_data : 32'h0;
            default:         single_res = '0;
         endcase
      end
   end

   // Branch condition evaluation on the raw register operands
   always_comb begin
      case (br_funct3_e'(br_funct3))
         BR_BEQ:  br_cond = (rs1_data == rs2_data);
         BR_BNE:  br_cond = (rs1_data != rs2_data);
         BR_BLT:  br_cond = (sa < s2);
         BR_BGE:  br_cond = (sa >= s2);
         BR_BLTU: br_cond = (rs1_data < rs2_data);
         BR_BGEU: br_cond = (rs1_data >= rs2_data);
         default: br_cond = 1'b0;
      endcase
   end

   // Sequencing state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_d;
   end

   // Next state, stall and iterative-unit start
   always_comb begin
      state_d = state;
      stall   = 1'b0;
      start   = 1'b0;
      case (state)
         ST_IDLE: begin
            stall = in_valid && multi;
            if (!flush && in_valid && multi) begin
               state_d = ST_BUSY;
               start   = 1'b1;
            end
         end
         ST_BUSY: begin
            stall = md_busy && !md_done;
            if (flush || md_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   muldiv_unit u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .abort  (flush),
      .op     (op),
      .a      (rs1_data),
      .b      (opb),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   // Output register toward memory: completion, capture, or bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid     <= 1'b0;
         alu_result    <= '0;
         store_data    <= '0;
         out_ctrl      <= '0;
         out_RegDest   <= '0;
         branch_taken  <= 1'b0;
         branch_target <= '0;
      end else if (flush) begin
         out_valid    <= 1'b0;
         out_ctrl     <= '0;
         branch_taken <= 1'b0;
      end else if (state == ST_BUSY && md_done) begin
         out_valid     <= 1'b1;
         alu_result    <= md_result;
         store_data    <= rs2_data;
         out_ctrl      <= in_ctrl;
         out_RegDest   <= in_RegDest;
         branch_taken  <= 1'b0;
         branch_target <= pc + imm;
      end else if (state == ST_IDLE && in_valid && !stall) begin
         out_valid     <= 1'b1;
         alu_result    <= single_res;
         store_data    <= rs2_data;
         out_ctrl      <= in_ctrl;
         out_RegDest   <= in_RegDest;
         branch_taken  <= Jump || (Branch && br_cond);
         branch_target <= pc + imm;
      end else begin
         out_valid    <= 1'b0;
         out_ctrl     <= '0;
         branch_taken <= 1'b0;
      end
   end

endmodule
